ctrl_unit: RTL and testbench

RV32I instruction decoder for the single-issue core: takes the fetched 32-bit instruction and produces the control signals consumed by the ALU, register file, PC/branch logic and load/store unit. It sits between fetch and execute. In the default build it is purely combinational. The clock and reset are used only when output registering is compiled in.

---
 rtl/rv_isa_pkg.sv | 42 ++++
 rtl/ctrl_unit.sv | 132 +++++++++++++
 tb/tb_ctrl_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I opcodes, ALU funct3 codes and the decoded control bundle
package rv_isa_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SLL  = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] XOR  = 3'b100;
    localparam logic [2:0] SR   = 3'b101;
    localparam logic [2:0] OR   = 3'b110;
    localparam logic [2:0] AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_imm;
        logic       alu_sub;
        logic       alu_sra;
        logic       rd_w;
        logic       ld_upper;
        logic       add_pc;
        logic       jmp_reg;
        logic       is_branch;
        logic       is_jmp;
        logic       is_load;
        logic       is_store;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_unit.sv
// ctrl_unit: RV32I instruction decoder; combinational by default,
// one-cycle registered outputs when CTRL_UNIT_OUTREG_EN is defined.
module ctrl_unit
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] inst,
    output logic [2:0]      alu_op,
    output logic            alu_imm,
    output logic            alu_sub,
    output logic            alu_sra,
    output logic            rd_w,
    output logic            ld_upper,
    output logic            add_pc,
    output logic            jmp_reg,
    output logic            is_branch,
    output logic            is_jmp,
    output logic            is_load,
    output logic            is_store,
    output logic            illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       b30;
    logic       ok;
    ctrl_t      d;
    ctrl_t      q;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign b30 = inst[30];

    always_comb begin
        d  = '0;
        ok = 1'b0;
        case (opc)
            OPC_LUI: begin
                ok         = 1'b1;
                d.rd_w     = 1'b1;
                d.ld_upper = 1'b1;
            end
            OPC_AUIPC: begin
                ok       = 1'b1;
                d.rd_w   = 1'b1;
                d.add_pc = 1'b1;
            end
            OPC_JAL: begin
                ok       = 1'b1;
                d.rd_w   = 1'b1;
                d.is_jmp = 1'b1;
            end
            OPC_JALR: begin
                ok        = f3 == ADD;
                d.rd_w    = 1'b1;
                d.is_jmp  = 1'b1;
                d.jmp_reg = 1'b1;
                d.alu_imm = 1'b1;
            end
            OPC_BRANCH: begin
                ok          = f3 != SLT && f3 != SLTU;
                d.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                ok        = f3 != SLTU && f3[2:1] != 2'b11;
                d.rd_w    = 1'b1;
                d.alu_imm = 1'b1;
                d.is_load = 1'b1;
            end
            OPC_STORE: begin
                ok         = !f3[2] && f3 != SLTU;
                d.alu_imm  = 1'b1;
                d.is_store = 1'b1;
            end
            // Only the shift immediates carry a funct7 field
            OPC_OPIMM: begin
                ok        = f3 == SLL ? f7 == F7_BASE :
                            f3 == SR  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
                d.rd_w    = 1'b1;
                d.alu_imm = 1'b1;
                d.alu_op  = f3;
                d.alu_sra = f3 == SR && b30;
            end
            OPC_OP: begin
                ok        = f7 == F7_BASE || (f7 == F7_ALT && (f3 == ADD || f3 == SR));
                d.rd_w    = 1'b1;
                d.alu_op  = f3;
                d.alu_sub = f3 == ADD && b30;
                d.alu_sra = f3 == SR && b30;
            end
            default: ok = 1'b0;
        endcase
        if (!ok || inst[1:0] != 2'b11) begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

`ifdef CTRL_UNIT_OUTREG_EN
    logic unused;
    assign unused = ^{inst[24:15], inst[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end
`else
    logic unused;
    assign unused = ^{clk, rst_n, inst[24:15], inst[11:7]};
    assign q = d;
`endif

    assign alu_op    = q.alu_op;
    assign alu_imm   = q.alu_imm;
    assign alu_sub   = q.alu_sub;
    assign alu_sra   = q.alu_sra;
    assign rd_w      = q.rd_w;
    assign ld_upper  = q.ld_upper;
    assign add_pc    = q.add_pc;
    assign jmp_reg   = q.jmp_reg;
    assign is_branch = q.is_branch;
    assign is_jmp    = q.is_jmp;
    assign is_load   = q.is_load;
    assign is_store  = q.is_store;
    assign illegal   = q.illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: table-driven scoreboard bench for ctrl_unit; follows
// CTRL_UNIT_OUTREG_EN to expect zero- or one-cycle output latency.
module tb_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [2:0]  alu_op;
    logic        alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc, jmp_reg;
    logic        is_branch, is_jmp, is_load, is_store, illegal;

    int errors = 0;
    int checks = 0;

    ctrl_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst),
        .alu_op(alu_op), .alu_imm(alu_imm), .alu_sub(alu_sub), .alu_sra(alu_sra),
        .rd_w(rd_w), .ld_upper(ld_upper), .add_pc(add_pc), .jmp_reg(jmp_reg),
        .is_branch(is_branch), .is_jmp(is_jmp), .is_load(is_load),
        .is_store(is_store), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected word layout: {illegal, alu_op[2:0], flags[10:0]}
    localparam logic [10:0] IMM = 11'b10000000000;
    localparam logic [10:0] SUB = 11'b01000000000;
    localparam logic [10:0] SRA = 11'b00100000000;
    localparam logic [10:0] RDW = 11'b00010000000;
    localparam logic [10:0] LUI = 11'b00001000000;
    localparam logic [10:0] APC = 11'b00000100000;
    localparam logic [10:0] JR  = 11'b00000010000;
    localparam logic [10:0] BR  = 11'b00000001000;
    localparam logic [10:0] JMP = 11'b00000000100;
    localparam logic [10:0] LD  = 11'b00000000010;
    localparam logic [10:0] ST  = 11'b00000000001;
    localparam logic [14:0] ILL = 15'h4000;

    typedef struct {
        logic [31:0] inst;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] sb[$];

    function automatic logic [14:0] mk(input logic [2:0] op, input logic [10:0] f);
        return {1'b0, op, f};
    endfunction

    function automatic logic [14:0] got();
        return {illegal, alu_op, alu_imm, alu_sub, alu_sra, rd_w, ld_upper,
                add_pc, jmp_reg, is_branch, is_jmp, is_load, is_store};
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        checks++;
        if (got() !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got(), exp);
        end
    endtask

    task automatic compare_next(input string name);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, sb.pop_front());
        end
    endtask

    // Drive one instruction, queue its expectation, compare once the DUT presents it
    task automatic apply(input logic [31:0] i, input logic [14:0] e, input string name);
        inst = i;
        sb.push_back(e);
`ifdef CTRL_UNIT_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        compare_next(name);
    endtask

    initial begin
        vecs.push_back('{32'h00000033, mk(3'b000, RDW), "add"});
        vecs.push_back('{32'h40000033, mk(3'b000, RDW | SUB), "sub"});
        vecs.push_back('{32'h40005033, mk(3'b101, RDW | SRA), "sra"});
        vecs.push_back('{32'h00005033, mk(3'b101, RDW), "srl"});
        vecs.push_back('{32'h00004033, mk(3'b100, RDW), "xor"});
        vecs.push_back('{32'h40003033, ILL, "sltu_f7alt"});
        vecs.push_back('{32'h02000033, ILL, "op_f7_0000001"});
        vecs.push_back('{32'h00005013, mk(3'b101, RDW | IMM), "srli"});
        vecs.push_back('{32'h40005013, mk(3'b101, RDW | IMM | SRA), "srai"});
        vecs.push_back('{32'h00002013, mk(3'b010, RDW | IMM), "slti"});
        vecs.push_back('{32'h40000013, mk(3'b000, RDW | IMM), "addi_bit30"});
        vecs.push_back('{32'h00001013, mk(3'b001, RDW | IMM), "slli"});
        vecs.push_back('{32'h40001013, ILL, "slli_f7alt"});
        vecs.push_back('{32'h02005013, ILL, "srli_f7bad"});
        vecs.push_back('{32'h00002003, mk(3'b000, RDW | IMM | LD), "lw"});
        vecs.push_back('{32'h00004003, mk(3'b000, RDW | IMM | LD), "lbu"});
        vecs.push_back('{32'h00003003, ILL, "load_f3_011"});
        vecs.push_back('{32'h00006003, ILL, "load_f3_110"});
        vecs.push_back('{32'h00002023, mk(3'b000, IMM | ST), "sw"});
        vecs.push_back('{32'h00003023, ILL, "store_f3_011"});
        vecs.push_back('{32'h00000037, mk(3'b000, RDW | LUI), "lui"});
        vecs.push_back('{32'hFFFFF0B7, mk(3'b000, RDW | LUI), "lui_upper"});
        vecs.push_back('{32'h00000017, mk(3'b000, RDW | APC), "auipc"});
        vecs.push_back('{32'h0000006F, mk(3'b000, RDW | JMP), "jal"});
        vecs.push_back('{32'h00000067, mk(3'b000, RDW | JMP | JR | IMM), "jalr"});
        vecs.push_back('{32'h00001067, ILL, "jalr_f3_001"});
        vecs.push_back('{32'h00000063, mk(3'b000, BR), "beq"});
        vecs.push_back('{32'h00007063, mk(3'b000, BR), "bgeu"});
        vecs.push_back('{32'h00002063, ILL, "branch_f3_010"});
        vecs.push_back('{32'h00003063, ILL, "branch_f3_011"});
        vecs.push_back('{32'h00000000, ILL, "zero"});
        vecs.push_back('{32'hFFFFFFFF, ILL, "ones"});
        vecs.push_back('{32'h00000032, ILL, "low_bits_10"});

        inst = 32'h00000033;
        #3;
`ifdef CTRL_UNIT_OUTREG_EN
        check("reset_state", 15'h0);
`else
        check("reset_ignored", mk(3'b000, RDW));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) apply(vecs[k].inst, vecs[k].exp, vecs[k].name);

`ifdef CTRL_UNIT_OUTREG_EN
        apply(32'h00000037, mk(3'b000, RDW | LUI), "lag_a");
        inst = 32'h00000063;
        #2;
        check("lag_hold", mk(3'b000, RDW | LUI));
        @(posedge clk);
        #1;
        check("lag_update", mk(3'b000, BR));
        inst = 32'h00000000;
        @(posedge clk);
        #1;
        check("illegal_reg", ILL);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clear", 15'h0);
        inst = 32'h0000006F;
        @(posedge clk);
        #1;
        check("reset_hold", 15'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", mk(3'b000, RDW | JMP));
`else
        inst = 32'h40000033;
        #1;
        check("seq_sub", mk(3'b000, RDW | SUB));
        inst[30] = 1'b0;
        #1;
        check("seq_bit30_clear", mk(3'b000, RDW));
        inst[25] = 1'b1;
        #1;
        check("seq_f7_bit25", ILL);
        inst = 32'h00000067;
        #1;
        check("seq_jalr", mk(3'b000, RDW | JMP | JR | IMM));
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
